// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU operation codes and result bundle
// for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;

    localparam logic [SEL_W-1:0] SEL_MAX = 5'd15;

    localparam logic [SEL_W-1:0] OP_AND  = 5'd0;
    localparam logic [SEL_W-1:0] OP_OR   = 5'd1;
    localparam logic [SEL_W-1:0] OP_ADD  = 5'd2;
    localparam logic [SEL_W-1:0] OP_SUB  = 5'd3;
    localparam logic [SEL_W-1:0] OP_XOR  = 5'd4;
    localparam logic [SEL_W-1:0] OP_NOR  = 5'd5;
    localparam logic [SEL_W-1:0] OP_ANDN = 5'd6;
    localparam logic [SEL_W-1:0] OP_SLL  = 5'd7;
    localparam logic [SEL_W-1:0] OP_SRL  = 5'd8;
    localparam logic [SEL_W-1:0] OP_SRA  = 5'd9;
    localparam logic [SEL_W-1:0] OP_PASA = 5'd10;
    localparam logic [SEL_W-1:0] OP_PASB = 5'd11;
    localparam logic [SEL_W-1:0] OP_SLT  = 5'd12;
    localparam logic [SEL_W-1:0] OP_SLTU = 5'd13;
    localparam logic [SEL_W-1:0] OP_SEQ  = 5'd14;
    localparam logic [SEL_W-1:0] OP_SNE  = 5'd15;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              id;
        logic              err;
    } res_t;

    function automatic logic sel_legal(input logic [SEL_W-1:0] s);
        return s <= SEL_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU datapath; shifts take
// the amount from op1 and shift op2.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [DATA_W-1:0] result_o
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = op1_i[4:0];
    assign lt_s  = $signed(op1_i) < $signed(op2_i);
    assign lt_u  = op1_i < op2_i;

    // Operation select; undefined codes yield zero
    always_comb begin
        result_o = '0;
        case (sel_i)
            OP_AND:  result_o = op1_i & op2_i;
            OP_OR:   result_o = op1_i | op2_i;
            OP_ADD:  result_o = op1_i + op2_i;
            OP_SUB:  result_o = op1_i - op2_i;
            OP_XOR:  result_o = op1_i ^ op2_i;
            OP_NOR:  result_o = ~(op1_i | op2_i);
            OP_ANDN: result_o = op1_i & ~op2_i;
            OP_SLL:  result_o = op2_i << shamt;
            OP_SRL:  result_o = op2_i >> shamt;
            OP_SRA:  result_o = DATA_W'($signed(op2_i) >>> shamt);
            OP_PASA: result_o = op1_i;
            OP_PASB: result_o = op2_i;
            OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, lt_u};
            OP_SEQ:  result_o = {{(DATA_W-1){1'b0}}, op1_i == op2_i};
            OP_SNE:  result_o = {{(DATA_W-1){1'b0}}, op1_i != op2_i};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// requesters, with a single registered result slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] op1_0,
    input  logic [DATA_W-1:0] op2_0,
    input  logic [DATA_W-1:0] op1_1,
    input  logic [DATA_W-1:0] op2_1,
    input  logic [SEL_W-1:0]  sel0,
    input  logic [SEL_W-1:0]  sel1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_id,
    output logic              out_err
);

    logic              valid_q;
    res_t              res_q;
    res_t              res_d;
    logic              ptr_q;
    logic              ptr_d;
    logic              slot_free;
    logic [DATA_W-1:0] a_op1;
    logic [DATA_W-1:0] a_op2;
    logic [SEL_W-1:0]  a_sel;
    logic [DATA_W-1:0] alu_res;
    logic              legal;

    assign slot_free = !valid_q || out_ready;

    // Grant: ptr_q=1 means requester 1 wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && slot_free) begin
            if (req0 && (!req1 || !ptr_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Pointer moves away from whoever was just granted
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    // Route the granted requester into the ALU
    always_comb begin
        a_op1 = gnt1 ? op1_1 : op1_0;
        a_op2 = gnt1 ? op2_1 : op2_0;
        a_sel = gnt1 ? sel1  : sel0;
    end

    alu_arbiter_alu u_alu (
        .op1_i    (a_op1),
        .op2_i    (a_op2),
        .sel_i    (a_sel),
        .result_o (alu_res)
    );

    // Illegal codes produce a zero result flagged as error
    always_comb begin
        legal         = sel_legal(a_sel);
        res_d.result  = legal ? alu_res : '0;
        res_d.zero    = legal ? (alu_res == '0) : 1'b1;
        res_d.id      = gnt1;
        res_d.err     = !legal;
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Result slot: load on grant, drain on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (gnt0 || gnt1) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = res_q.result;
    assign out_zero   = res_q.zero;
    assign out_id     = res_q.id;
    assign out_err    = res_q.err;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req0 / req1  input  1  requester k holds a pending operation.
REQ-004 SHALL have ports: op1_0, op2_0 / op1_1, op2_1  input  32  operands of requester k, held stable while reqk=1.
REQ-005 SHALL have ports: sel0 / sel1  input  5  ALU operation code of requester k (0-15 legal).
REQ-006 SHALL have ports: gnt0 / gnt1  output  1  combinational; operands of requester k are consumed this cycle.
REQ-007 SHALL have port: out_valid  output  1  registered result available.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.
REQ-009 SHALL have ports: out_result  output  32, out_zero  output  1, out_id  output  1 (granted requester), out_err  output  1 (illegal sel).

Function
REQ-010 SHALL define slot_free = !out_valid | out_ready; no grant when slot_free=0.
REQ-011 SHALL assert at most one of gnt0/gnt1 per cycle; gntk=0 whenever reqk=0.
REQ-012 SHALL grant the single requester when only one reqk=1 and slot_free=1.
REQ-013 SHALL, when both request and slot_free=1, grant the requester not granted most recently (round-robin pointer).
REQ-014 SHALL update the pointer only on a cycle with a grant; pointer is unchanged during back-pressure.
REQ-015 SHALL drive the shared ALU combinationally with the granted requester's op1/op2/sel.
REQ-016 SHALL, on a grant in cycle N, register out_result/out_zero/out_id/out_err and set out_valid=1 in cycle N+1 (latency 1).
REQ-017 SHALL hold out_result/out_zero/out_id/out_err/out_valid unchanged while out_valid=1 and out_ready=0.
REQ-018 SHALL, on out_valid=1 & out_ready=1 with a grant in the same cycle, load the new result (back-to-back, one result per cycle).
REQ-019 SHALL, on out_valid=1 & out_ready=1 with no grant, clear out_valid next cycle.
REQ-020 SHALL treat sel 16-31 as illegal: registered out_result=0, out_zero=1, out_err=1; grant and pointer behave as legal.
REQ-021 SHALL present a requester's new operation only after its gnt; a req dropped before gnt is lost without error.

Reset
REQ-022 SHALL, while reset=1 at a clock edge, set out_valid=0, out_result=0, out_zero=0, out_id=0, out_err=0, pointer preferring requester 0.
REQ-023 SHALL force gnt0=gnt1=0 during any cycle reset=1; an in-flight result is discarded.
REQ-024 SHALL take first grant in the first cycle after reset deasserts if a req is high.

Structure
REQ-025 SHALL place in a shared package: data width 32, sel width 5, max legal sel 15, named constants for the 16 ALU operation codes.
REQ-026 SHALL instantiate exactly one existing ALU datapath module as its sole sub-module; arbitration, pointer and output register are local.
REQ-027 SHALL contain no latches; every combinational output fully assigned.

Verification
REQ-028 SHALL cover: req0=1, op1_0=5, op2_0=7, sel0=2, out_ready=1 -> gnt0 same cycle; next cycle out_valid=1, out_result=12, out_zero=0, out_id=0.
REQ-029 SHALL cover: req0=req1=1 held 4 cycles, out_ready=1 -> grants 0,1,0,1; out_id sequence 0,1,0,1 one cycle later.
REQ-030 SHALL cover: out_valid=1, out_ready=0 for 3 cycles with both reqs high -> no gnt, outputs frozen; out_ready=1 -> grant resumes with pointer unchanged.
REQ-031 SHALL cover: req1=1, sel1=20 -> gnt1; next cycle out_result=0, out_zero=1, out_err=1, out_id=1.
REQ-032 SHALL cover: req1=1, op1_1=3, op2_1=3, sel1=3 -> out_result=0, out_zero=1, out_err=0; then reset=1 while out_valid=1 -> next cycle out_valid=0, all outputs 0.
REQ-033 SHALL cover: sel=9, op1=4, op2=0x80000000 -> out_result=0xF8000000; sel=12, op1=0xFFFFFFFF, op2=1 -> out_result=1.
